// File: rtl/fdiv_sched.sv
// Multi-channel programmable frequency divider: per-channel tick strobe and 50% square wave,
// with one queued ratio/enable update per channel that is applied only at a period boundary.
module fdiv_sched #(
    parameter int NCH = 4,
    parameter int DW  = 8,
    parameter int CW  = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [CW-1:0]  cfg_ch,
    input  logic [DW-1:0]  cfg_div,
    input  logic           cfg_en,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] fout,
    output logic [NCH-1:0] busy
);

    typedef enum logic {OFF = 1'b0, RUN = 1'b1} state_t;

    logic [NCH-1:0] pending;

    // Channel indices beyond NCH have no queue, so they are always ready and simply dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_ch == CW'(i)) begin
                cfg_ready = ~pending[i];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            state_t        state_reg, state_next;
            logic [DW-1:0] cnt_reg, cnt_next;
            logic [DW-1:0] act_reg, act_next;
            logic [DW-1:0] shd_reg, shd_next;
            logic          shd_en_reg, shd_en_next;
            logic          pend_reg, pend_next;
            logic          tick_reg, tick_next;
            logic          fout_reg, fout_next;
            logic          accept;
            logic          terminal;

            assign accept   = cfg_valid & cfg_ready & (cfg_ch == CW'(gi));
            assign terminal = (cnt_reg == act_reg - DW'(1));

            always_comb begin
                state_next  = state_reg;
                cnt_next    = cnt_reg;
                act_next    = act_reg;
                shd_next    = shd_reg;
                shd_en_next = shd_en_reg;
                pend_next   = pend_reg;
                tick_next   = tick_reg;
                fout_next   = fout_reg;

                // An accept only happens while pend_reg is clear, so it never collides
                // with the apply paths below.
                if (accept) begin
                    shd_next    = cfg_div;
                    shd_en_next = cfg_en & (cfg_div != '0);
                    pend_next   = 1'b1;
                end

                case (state_reg)
                    OFF: begin
                        tick_next = 1'b0;
                        fout_next = 1'b0;
                        cnt_next  = '0;
                        if (pend_reg) begin
                            act_next  = shd_reg;
                            pend_next = 1'b0;
                            if (shd_en_reg) begin
                                state_next = RUN;
                            end
                        end
                    end
                    RUN: begin
                        if (terminal) begin
                            cnt_next  = '0;
                            tick_next = 1'b1;
                            fout_next = ~fout_reg;
                            if (pend_reg) begin
                                act_next  = shd_reg;
                                pend_next = 1'b0;
                                if (!shd_en_reg) begin
                                    state_next = OFF;
                                    fout_next  = 1'b0;
                                end
                            end
                        end else begin
                            cnt_next  = cnt_reg + DW'(1);
                            tick_next = 1'b0;
                        end
                    end
                    default: begin
                        state_next = OFF;
                    end
                endcase
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_reg  <= OFF;
                    cnt_reg    <= '0;
                    act_reg    <= '0;
                    shd_reg    <= '0;
                    shd_en_reg <= 1'b0;
                    pend_reg   <= 1'b0;
                    tick_reg   <= 1'b0;
                    fout_reg   <= 1'b0;
                end else begin
                    state_reg  <= state_next;
                    cnt_reg    <= cnt_next;
                    act_reg    <= act_next;
                    shd_reg    <= shd_next;
                    shd_en_reg <= shd_en_next;
                    pend_reg   <= pend_next;
                    tick_reg   <= tick_next;
                    fout_reg   <= fout_next;
                end
            end

            assign pending[gi] = pend_reg;
            assign tick[gi]    = tick_reg;
            assign fout[gi]    = fout_reg;
            assign busy[gi]    = (state_reg == RUN);
        end
    endgenerate

endmodule

// File: tb/tb_fdiv_sched.sv
// Directed bench for fdiv_sched: reset, basic ratios, DIV=1, boundary-aligned retune,
// stop/disable and per-channel backpressure with channel independence.
module tb_fdiv_sched;

    logic       clk;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic       cfg_en;
    logic [3:0] tick;
    logic [3:0] fout;
    logic [3:0] busy;

    int tests = 0;
    int fails = 0;
    int w;
    int nt;

    fdiv_sched #(.NCH(4), .DW(8), .CW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_en    (cfg_en),
        .tick      (tick),
        .fout      (fout),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds the request until cfg_ready is seen, returns the number of extra cycles waited.
    task automatic send(input logic [1:0] ch, input logic [7:0] div, input logic en,
                        output int waited);
        waited    = 0;
        cfg_ch    = ch;
        cfg_div   = div;
        cfg_en    = en;
        cfg_valid = 1'b1;
        @(negedge clk);
        while (!cfg_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("send_timeout", 32'(waited < 50), 32'd1);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_div = 8'd0; cfg_en = 1'b0;
        #1 rst = 1'b1;
        #11 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("init_tick", 32'(tick), 32'h0);
        chk("init_fout", 32'(fout), 32'h0);
        chk("init_busy", 32'(busy), 32'h0);
        chk("init_ready", 32'(cfg_ready), 32'd1);

        // T1: ch0 DIV=3, second write lands on the first terminal edge, then async reset
        send(2'd0, 8'd3, 1'b1, w);
        step(3);
        send(2'd0, 8'd3, 1'b1, w);
        chk("t1_tick_pre", 32'(tick), 32'h1);
        chk("t1_fout_pre", 32'(fout), 32'h1);
        chk("t1_busy_pre", 32'(busy), 32'h1);
        chk("t1_ready_pre", 32'(cfg_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("t1_tick_rst", 32'(tick), 32'h0);
        chk("t1_fout_rst", 32'(fout), 32'h0);
        chk("t1_busy_rst", 32'(busy), 32'h0);
        chk("t1_ready_rst", 32'(cfg_ready), 32'd1);
        #1 rst = 1'b0;
        step(2);
        chk("t1_busy_after", 32'(busy), 32'h0);
        chk("t1_tick_after", 32'(tick), 32'h0);

        // T3: ch0 DIV=1 -> tick stuck high, fout = clk/2
        send(2'd0, 8'd1, 1'b1, w);
        chk("t3_busy_e0", 32'(busy), 32'h0);
        step(1);
        chk("t3_busy_e1", 32'(busy), 32'h1);
        chk("t3_tick_e1", 32'(tick), 32'h0);
        for (int k = 2; k <= 7; k++) begin
            step(1);
            chk("t3_tick", 32'(tick), 32'h1);
            chk("t3_fout", 32'(fout), 32'((k % 2) == 0));
        end

        // T2: ch1 DIV=3 -> ticks at E4, E7, E10
        do_reset();
        send(2'd1, 8'd3, 1'b1, w);
        chk("t2_busy_e0", 32'(busy), 32'h0);
        step(1);
        chk("t2_busy_e1", 32'(busy), 32'h2);
        nt = 0;
        for (int k = 2; k <= 10; k++) begin
            step(1);
            if (k >= 4 && ((k - 4) % 3) == 0) nt++;
            chk("t2_tick", 32'(tick), (k >= 4 && ((k - 4) % 3) == 0) ? 32'h2 : 32'h0);
            chk("t2_fout", 32'(fout), (nt % 2 == 1) ? 32'h2 : 32'h0);
        end

        // T4: ch2 DIV=4 retuned to 2 mid-period
        do_reset();
        send(2'd2, 8'd4, 1'b1, w);
        step(5);
        chk("t4_tick_e5", 32'(tick), 32'h4);
        chk("t4_fout_e5", 32'(fout), 32'h4);
        step(1);
        chk("t4_tick_e6", 32'(tick), 32'h0);
        send(2'd2, 8'd2, 1'b1, w);
        chk("t4_ready_e7", 32'(cfg_ready), 32'd0);
        chk("t4_tick_e7", 32'(tick), 32'h0);
        step(1);
        chk("t4_ready_e8", 32'(cfg_ready), 32'd0);
        chk("t4_tick_e8", 32'(tick), 32'h0);
        step(1);
        chk("t4_ready_e9", 32'(cfg_ready), 32'd1);
        chk("t4_tick_e9", 32'(tick), 32'h4);
        chk("t4_fout_e9", 32'(fout), 32'h0);
        step(1);
        chk("t4_tick_e10", 32'(tick), 32'h0);
        step(1);
        chk("t4_tick_e11", 32'(tick), 32'h4);
        chk("t4_fout_e11", 32'(fout), 32'h4);
        step(1);
        chk("t4_tick_e12", 32'(tick), 32'h0);
        step(1);
        chk("t4_tick_e13", 32'(tick), 32'h4);
        chk("t4_fout_e13", 32'(fout), 32'h0);

        // T5a: ch3 DIV=5 stopped with en=0; boundary at E16 where fout would have risen
        do_reset();
        send(2'd3, 8'd5, 1'b1, w);
        step(6);
        chk("t5_tick_e6", 32'(tick), 32'h8);
        chk("t5_fout_e6", 32'(fout), 32'h8);
        step(6);
        send(2'd3, 8'd5, 1'b0, w);
        chk("t5_ready_e13", 32'(cfg_ready), 32'd0);
        step(2);
        chk("t5_busy_e15", 32'(busy), 32'h8);
        chk("t5_fout_e15", 32'(fout), 32'h0);
        step(1);
        chk("t5_tick_e16", 32'(tick), 32'h8);
        chk("t5_fout_e16", 32'(fout), 32'h0);
        chk("t5_busy_e16", 32'(busy), 32'h0);
        step(1);
        chk("t5_tick_e17", 32'(tick), 32'h0);
        chk("t5_ready_e17", 32'(cfg_ready), 32'd1);

        // T5b: restart ch3 DIV=5, then disable with DIV=0
        send(2'd3, 8'd5, 1'b1, w);
        step(6);
        chk("t5b_tick_f6", 32'(tick), 32'h8);
        step(6);
        send(2'd3, 8'd0, 1'b1, w);
        step(2);
        chk("t5b_busy_f15", 32'(busy), 32'h8);
        step(1);
        chk("t5b_tick_f16", 32'(tick), 32'h8);
        chk("t5b_fout_f16", 32'(fout), 32'h0);
        chk("t5b_busy_f16", 32'(busy), 32'h0);
        step(4);
        chk("t5b_tick_f20", 32'(tick), 32'h0);
        chk("t5b_busy_f20", 32'(busy), 32'h0);

        // T6: ch0 DIV=2 and ch1 DIV=3; back-to-back ch1 writes with a ch0 write in between
        do_reset();
        send(2'd0, 8'd2, 1'b1, w);
        send(2'd1, 8'd3, 1'b1, w);
        step(4);
        chk("t6_tick_e5", 32'(tick), 32'h3);
        send(2'd1, 8'd3, 1'b1, w);
        chk("t6_wait_ch1a", 32'(w), 32'd0);
        send(2'd0, 8'd2, 1'b1, w);
        chk("t6_wait_ch0", 32'(w), 32'd0);
        chk("t6_tick_e7", 32'(tick), 32'h1);
        send(2'd1, 8'd2, 1'b1, w);
        chk("t6_wait_ch1b", 32'(w), 32'd1);
        chk("t6_tick_e9", 32'(tick), 32'h1);
        for (int e = 10; e <= 15; e++) begin
            step(1);
            chk("t6_tick", 32'(tick), ((e % 2) == 1) ? 32'h3 : 32'h0);
        end
        chk("t6_busy", 32'(busy), 32'h3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
